// File: rtl/mips_trace_buf.sv
// Instruction-trace capture buffer for the multicycle MIPS core: records one {PC, IR}
// pair per IR-load strobe into a FIFO, with optional PC trigger and stop/wrap-on-full.
module mips_trace_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int WRAP   = 0,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [DATA_W-1:0]        ir_i,
    input  logic                     commit_i,
    input  logic                     arm_i,
    input  logic                     trig_en_i,
    input  logic [ADDR_W-1:0]        trig_pc_i,
    input  logic                     clear_i,
    input  logic                     rd_en_i,
    output logic                     rd_valid_o,
    output logic [ADDR_W-1:0]        rd_pc_o,
    output logic [DATA_W-1:0]        rd_ir_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [DROP_W-1:0]        dropped_o,
    output logic [1:0]               state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam bit WRAP_EN = (WRAP != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t              state_p0;
    state_t              state_nxt;
    logic [PTR_W-1:0]    wr_ptr_p0;
    logic [PTR_W-1:0]    rd_ptr_p0;
    logic [CNT_W-1:0]    count_p0;
    logic [CNT_W-1:0]    count_nxt;
    logic                empty_p0;
    logic                full_p0;
    logic [DROP_W-1:0]   dropped_p0;
    logic [REC_W-1:0]    mem [DEPTH];

    logic                vld_p1;
    logic [ADDR_W-1:0]   rd_pc_p1;
    logic [DATA_W-1:0]   rd_ir_p1;

    logic                trig_hit;
    logic                cap_commit;
    logic                pop;
    logic                drop;
    logic                overwrite;
    logic                wr_en;
    logic                flush;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign flush      = rst || clear_i;
    assign trig_hit   = commit_i && (pc_i == trig_pc_i);
    assign pop        = rd_en_i && !empty_p0;
    // The triggering instruction itself is captured, so WAIT_TRIG behaves like CAPTURE on a hit.
    assign cap_commit = (commit_i && (state_p0 == S_CAPT)) ||
                        ((state_p0 == S_WAIT) && trig_hit);
    // A same-cycle pop frees the slot, so a commit at full is only a loss without one.
    assign drop       = cap_commit && full_p0 && !pop;
    assign overwrite  = drop && WRAP_EN;
    assign wr_en      = cap_commit && (!drop || WRAP_EN);

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            S_IDLE, S_STOP: begin
                if (arm_i) state_nxt = trig_en_i ? S_WAIT : S_CAPT;
            end
            S_WAIT: begin
                if (trig_hit) state_nxt = (drop && !WRAP_EN) ? S_STOP : S_CAPT;
            end
            S_CAPT: begin
                if (drop && !WRAP_EN) state_nxt = S_STOP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count_p0;
        if (wr_en && !pop && !overwrite)
            count_nxt = count_p0 + 1'b1;
        else if (pop && !wr_en)
            count_nxt = count_p0 - 1'b1;
    end

    // p0: capture control, pointers and occupancy
    always_ff @(posedge clk) begin
        if (flush) begin
            state_p0   <= S_IDLE;
            wr_ptr_p0  <= '0;
            rd_ptr_p0  <= '0;
            count_p0   <= '0;
            empty_p0   <= 1'b1;
            full_p0    <= 1'b0;
            dropped_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (wr_en)
                wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
            if (pop || overwrite)
                rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
            count_p0 <= count_nxt;
            empty_p0 <= (count_nxt == '0);
            full_p0  <= (count_nxt == FULL_CNT);
            if (drop)
                dropped_p0 <= sat_inc(dropped_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[wr_ptr_p0] <= {pc_i, ir_i};
    end

    // p1: registered read-out; a pop at full alongside a write reads the pre-write oldest record
    always_ff @(posedge clk) begin
        if (flush) begin
            vld_p1   <= 1'b0;
            rd_pc_p1 <= '0;
            rd_ir_p1 <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop)
                {rd_pc_p1, rd_ir_p1} <= mem[rd_ptr_p0];
        end
    end

    assign rd_valid_o = vld_p1;
    assign rd_pc_o    = rd_pc_p1;
    assign rd_ir_o    = rd_ir_p1;
    assign count_o    = count_p0;
    assign empty_o    = empty_p0;
    assign full_o     = full_p0;
    assign dropped_o  = dropped_p0;
    assign state_o    = state_p0;

endmodule
